// File: rtl/serial_addsub.sv
// serial_addsub -- bit-serial adder/subtractor, one result bit per clock.
//
// Operations selected by mode (latched at accept):
//   00  two's complement add       A + B
//   01  two's complement subtract  A - B   (A + ~B + 1)
//   10  ones' complement add       A + B with end-around carry
//   11  two's complement negate    -A      (0 + ~A + 1, B ignored)
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   start     request, sampled in IDLE (and on the edge leaving DONE)
//   mode[1:0] operation select
//   a, b      operands, WIDTH bits
//   busy      high from accept through the done cycle
//   done      one-cycle completion pulse
//   result    result, held until the next completion
//   carry     00 carry-out, 01 borrow, 10 end-around taken, 11 A==0
//   overflow  signed overflow (only with SERIAL_ADDSUB_OVF_EN defined,
//             otherwise tied to 0 with no logic built)
//
// Optional feature macro: SERIAL_ADDSUB_OVF_EN

module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, FIX, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic [1:0]       mode_q;
  logic [CW-1:0]    cnt;
  logic             cy;

  logic             accept, last, op_a, op_b, s_bit, c_out, flag_shift;
  logic [WIDTH-1:0] sum_shift, sum_inc;

  // A new request is taken in IDLE, and also on the edge leaving DONE so
  // that a held start produces back-to-back operations.
  always_comb begin
    accept    = start && ((state == IDLE) || (state == DONE));
    last      = (cnt == CW'(WIDTH - 1));
    op_a      = (mode_q == 2'b11) ? 1'b0 : a_q[cnt];
    case (mode_q)
      2'b01:   op_b = ~b_q[cnt];
      2'b11:   op_b = ~a_q[cnt];
      default: op_b = b_q[cnt];
    endcase
    s_bit     = op_a ^ op_b ^ cy;
    c_out     = (op_a & op_b) | (op_a & cy) | (op_b & cy);
    // Result bits enter at the MSB and move down, so after WIDTH shifts
    // bit 0 sits at the LSB.
    sum_shift = {s_bit, sum_q[WIDTH-1:1]};
    sum_inc   = sum_q + {{(WIDTH-1){1'b0}}, 1'b1};
    case (mode_q)
      2'b01:   flag_shift = ~c_out;
      2'b11:   flag_shift = (a_q == '0);
      default: flag_shift = c_out;
    endcase
  end

`ifdef SERIAL_ADDSUB_OVF_EN
  logic sign_a, sign_b, ovf_shift, ovf_fix;

  // Overflow compares the signs of the effective operands (after any
  // inversion) against the final result sign; negate overflows only on
  // the most negative value.
  always_comb begin
    sign_a = (mode_q == 2'b11) ? 1'b0 : a_q[WIDTH-1];
    case (mode_q)
      2'b01:   sign_b = ~b_q[WIDTH-1];
      2'b11:   sign_b = ~a_q[WIDTH-1];
      default: sign_b = b_q[WIDTH-1];
    endcase
    if (mode_q == 2'b11) begin
      ovf_shift = (a_q == {1'b1, {(WIDTH-1){1'b0}}});
    end else begin
      ovf_shift = (sign_a == sign_b) && (sign_a != sum_shift[WIDTH-1]);
    end
    ovf_fix = (sign_a == sign_b) && (sign_a != sum_inc[WIDTH-1]);
  end
`endif

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (accept) state_next = SHIFT;
      SHIFT: if (last) state_next = ((mode_q == 2'b10) && c_out) ? FIX : DONE;
      FIX:   state_next = DONE;
      DONE:  state_next = accept ? SHIFT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath and registered outputs. result/carry/overflow change only on
  // the edge that enters DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      mode_q <= '0;
      sum_q  <= '0;
      cnt    <= '0;
      cy     <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      carry  <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
      overflow <= 1'b0;
`endif
    end else begin
      busy <= (state_next != IDLE);
      done <= (state_next == DONE);
      if (accept) begin
        a_q    <= a;
        b_q    <= b;
        mode_q <= mode;
        sum_q  <= '0;
        cnt    <= '0;
        // Modes 01 and 11 need the +1 of a two's complement inversion.
        cy     <= mode[0];
      end else if (state == SHIFT) begin
        cnt   <= cnt + 1'b1;
        cy    <= c_out;
        sum_q <= sum_shift;
        if (last && (state_next == DONE)) begin
          result <= sum_shift;
          carry  <= flag_shift;
`ifdef SERIAL_ADDSUB_OVF_EN
          overflow <= ovf_shift;
`endif
        end
      end else if (state == FIX) begin
        // Negative zero (all ones) is deliberately left as is.
        result <= sum_inc;
        carry  <= 1'b1;
`ifdef SERIAL_ADDSUB_OVF_EN
        overflow <= ovf_fix;
`endif
      end
    end
  end

`ifndef SERIAL_ADDSUB_OVF_EN
  assign overflow = 1'b0;
`endif

endmodule
